// File: rtl/multi_stage_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : multi_stage_forwarding_unit
// Brief    : DEPTH-stage operand forwarding select and load-use stall unit
// Revision : 1.0 - initial release
// ============================================================================
module multi_stage_forwarding_unit #(
    parameter  int REG_W      = 3,
    parameter  int DATA_W     = 16,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_READY = 1,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_advance,
    input  logic                    i_flush,
    input  logic                    i_dec_valid,
    input  logic [REG_W-1:0]        i_dec_rs,
    input  logic [REG_W-1:0]        i_dec_rt,
    input  logic                    i_dec_use_rs,
    input  logic                    i_dec_use_rt,
    input  logic [REG_W-1:0]        i_dec_rd,
    input  logic                    i_dec_wb,
    input  logic                    i_dec_is_load,
    input  logic [DEPTH*DATA_W-1:0] i_stage_data,
    output logic [SEL_W-1:0]        o_fwd_sel_a,
    output logic [SEL_W-1:0]        o_fwd_sel_b,
    output logic [DATA_W-1:0]       o_fwd_data_a,
    output logic [DATA_W-1:0]       o_fwd_data_b,
    output logic                    o_stall,
    output logic [SEL_W-1:0]        o_pending_cnt
);

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_is_load;
    logic [REG_W-1:0] r_rd [DEPTH];

    logic [SEL_W-1:0]  w_sel_a;
    logic [SEL_W-1:0]  w_sel_b;
    logic [DATA_W-1:0] w_data_a;
    logic [DATA_W-1:0] w_data_b;
    logic              w_late_a;
    logic              w_late_b;
    logic              w_stall;
    logic [SEL_W-1:0]  w_cnt;

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_data_a = '0;
        w_data_b = '0;
        w_late_a = 1'b0;
        w_late_b = 1'b0;
        w_cnt    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_valid[k] && i_dec_use_rs && (r_rd[k] == i_dec_rs)) begin
                w_sel_a  = SEL_W'(k + 1);
                w_data_a = i_stage_data[k*DATA_W +: DATA_W];
                w_late_a = r_is_load[k] && (k < LOAD_READY);
            end
            if (r_valid[k] && i_dec_use_rt && (r_rd[k] == i_dec_rt)) begin
                w_sel_b  = SEL_W'(k + 1);
                w_data_b = i_stage_data[k*DATA_W +: DATA_W];
                w_late_b = r_is_load[k] && (k < LOAD_READY);
            end
            w_cnt = w_cnt + SEL_W'(r_valid[k]);
        end
        w_stall = i_dec_valid && !i_flush && (w_late_a || w_late_b);
    end

    // A flushed or stalled decode slot enters stage 0 as a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= '0;
            r_is_load <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else if (i_advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]   <= r_valid[k-1];
                r_is_load[k] <= r_is_load[k-1];
                r_rd[k]      <= r_rd[k-1];
            end
            r_valid[0]   <= i_dec_valid && i_dec_wb && !i_flush && !w_stall;
            r_is_load[0] <= i_dec_is_load;
            r_rd[0]      <= i_dec_rd;
        end
    end

    assign o_fwd_sel_a   = w_sel_a;
    assign o_fwd_sel_b   = w_sel_b;
    assign o_fwd_data_a  = w_data_a;
    assign o_fwd_data_b  = w_data_b;
    assign o_stall       = w_stall;
    assign o_pending_cnt = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multi_stage_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_stage_forwarding_unit
// Brief    : Scoreboard bench for the forwarding / load-use stall unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_stage_forwarding_unit;

    localparam int D  = 3;
    localparam int LR = 1;

    logic        i_clk;
    logic        i_rst;
    logic        i_advance;
    logic        i_flush;
    logic        i_dec_valid;
    logic [2:0]  i_dec_rs;
    logic [2:0]  i_dec_rt;
    logic        i_dec_use_rs;
    logic        i_dec_use_rt;
    logic [2:0]  i_dec_rd;
    logic        i_dec_wb;
    logic        i_dec_is_load;
    logic [47:0] i_stage_data;
    logic [1:0]  o_fwd_sel_a;
    logic [1:0]  o_fwd_sel_b;
    logic [15:0] o_fwd_data_a;
    logic [15:0] o_fwd_data_b;
    logic        o_stall;
    logic [1:0]  o_pending_cnt;

    multi_stage_forwarding_unit #(
        .REG_W(3), .DATA_W(16), .DEPTH(D), .LOAD_READY(LR)
    ) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_advance    (i_advance),
        .i_flush      (i_flush),
        .i_dec_valid  (i_dec_valid),
        .i_dec_rs     (i_dec_rs),
        .i_dec_rt     (i_dec_rt),
        .i_dec_use_rs (i_dec_use_rs),
        .i_dec_use_rt (i_dec_use_rt),
        .i_dec_rd     (i_dec_rd),
        .i_dec_wb     (i_dec_wb),
        .i_dec_is_load(i_dec_is_load),
        .i_stage_data (i_stage_data),
        .o_fwd_sel_a  (o_fwd_sel_a),
        .o_fwd_sel_b  (o_fwd_sel_b),
        .o_fwd_data_a (o_fwd_data_a),
        .o_fwd_data_b (o_fwd_data_b),
        .o_stall      (o_stall),
        .o_pending_cnt(o_pending_cnt)
    );

    typedef struct packed {
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [15:0] da;
        logic [15:0] db;
        logic        st;
        logic [1:0]  cnt;
    } exp_t;

    exp_t       q_exp[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       m_v  [D];
    logic [2:0] m_rd [D];
    logic       m_ld [D];
    logic [1:0]  obs_sa, obs_sb, obs_cnt;
    logic [15:0] obs_da, obs_db;
    logic        obs_st;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic la, lb;
        e  = '0;
        la = 1'b0;
        lb = 1'b0;
        for (int k = 0; k < D; k++) begin
            if (e.sa == 2'd0 && m_v[k] && i_dec_use_rs && m_rd[k] == i_dec_rs) begin
                e.sa = 2'(k + 1);
                e.da = i_stage_data[k*16 +: 16];
                la   = m_ld[k] && (k < LR);
            end
            if (e.sb == 2'd0 && m_v[k] && i_dec_use_rt && m_rd[k] == i_dec_rt) begin
                e.sb = 2'(k + 1);
                e.db = i_stage_data[k*16 +: 16];
                lb   = m_ld[k] && (k < LR);
            end
            if (m_v[k]) e.cnt = e.cnt + 2'd1;
        end
        e.st = i_dec_valid && !i_flush && (la || lb);
        return e;
    endfunction

    // One clock: push expectation, compare at negedge, then advance the model.
    task automatic cycle();
        exp_t e;
        exp_t got;
        q_exp.push_back(model_out());
        @(negedge i_clk);
        e = q_exp.pop_front();
        obs_sa = o_fwd_sel_a;  obs_sb = o_fwd_sel_b;
        obs_da = o_fwd_data_a; obs_db = o_fwd_data_b;
        obs_st = o_stall;      obs_cnt = o_pending_cnt;
        check("sel_a",  32'(obs_sa),  32'(e.sa));
        check("sel_b",  32'(obs_sb),  32'(e.sb));
        check("data_a", 32'(obs_da),  32'(e.da));
        check("data_b", 32'(obs_db),  32'(e.db));
        check("stall",  32'(obs_st),  32'(e.st));
        check("count",  32'(obs_cnt), 32'(e.cnt));
        got = e;
        @(posedge i_clk);
        if (i_rst) begin
            for (int k = 0; k < D; k++) begin
                m_v[k] = 1'b0; m_rd[k] = '0; m_ld[k] = 1'b0;
            end
        end else if (i_advance) begin
            for (int k = D - 1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[0]  = i_dec_valid && i_dec_wb && !i_flush && !got.st;
            m_rd[0] = i_dec_rd;
            m_ld[0] = i_dec_is_load;
        end
        #1;
    endtask

    task automatic set_dec(input logic adv, input logic fl, input logic dv,
                           input logic [2:0] rs, input logic urs,
                           input logic [2:0] rt, input logic urt,
                           input logic [2:0] rd, input logic wb, input logic ld);
        i_advance = adv; i_flush = fl; i_dec_valid = dv;
        i_dec_rs = rs; i_dec_use_rs = urs; i_dec_rt = rt; i_dec_use_rt = urt;
        i_dec_rd = rd; i_dec_wb = wb; i_dec_is_load = ld;
    endtask

    task automatic nops(input int n);
        set_dec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic randomize_inputs();
        i_advance = ($urandom_range(7) != 0);
        i_flush = ($urandom_range(9) == 0);
        i_dec_valid = ($urandom_range(3) != 0);
        i_dec_rs = 3'($urandom_range(7)); i_dec_rt = 3'($urandom_range(7));
        i_dec_use_rs = 1'($urandom_range(1)); i_dec_use_rt = 1'($urandom_range(1));
        i_dec_rd = 3'($urandom_range(7)); i_dec_wb = 1'($urandom_range(1));
        i_dec_is_load = 1'($urandom_range(1));
        i_stage_data = {16'($urandom), 16'($urandom), 16'($urandom)};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b1;
        randomize_inputs();
        @(posedge i_clk); #1;
        randomize_inputs();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int k = 0; k < D; k++) begin
            m_v[k] = 1'b0; m_rd[k] = '0; m_ld[k] = 1'b0;
        end

        // Reset state
        i_stage_data = {16'h1111, 16'h2222, 16'h3333};
        set_dec(1, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        cycle();
        check("rst_sel_a", 32'(obs_sa), 32'd0);
        check("rst_sel_b", 32'(obs_sb), 32'd0);
        check("rst_data_a", 32'(obs_da), 32'd0);
        check("rst_stall", 32'(obs_st), 32'd0);
        check("rst_cnt", 32'(obs_cnt), 32'd0);

        // Adjacent ALU dependency
        set_dec(1, 0, 1, 0, 0, 0, 0, 2, 1, 0); cycle();
        i_stage_data = {16'h0, 16'h0, 16'h1234};
        set_dec(1, 0, 1, 2, 1, 0, 0, 0, 0, 0); cycle();
        check("alu_sel_a", 32'(obs_sa), 32'd1);
        check("alu_data_a", 32'(obs_da), 32'h1234);
        check("alu_sel_b", 32'(obs_sb), 32'd0);
        check("alu_stall", 32'(obs_st), 32'd0);

        // Priority: only the stage-2 copy of R3, then both copies
        nops(3);
        i_stage_data = {16'h5555, 16'h0, 16'hAAAA};
        set_dec(1, 0, 1, 0, 0, 0, 0, 3, 1, 0); cycle();
        nops(2);
        set_dec(1, 0, 1, 0, 0, 3, 1, 0, 0, 0); cycle();
        check("prio_old_sel_b", 32'(obs_sb), 32'd3);
        check("prio_old_data_b", 32'(obs_db), 32'h5555);
        set_dec(1, 0, 1, 0, 0, 0, 0, 3, 1, 0); cycle();
        nops(1);
        set_dec(1, 0, 1, 0, 0, 0, 0, 3, 1, 0); cycle();
        set_dec(1, 0, 1, 0, 0, 3, 1, 0, 0, 0); cycle();
        check("prio_young_sel_b", 32'(obs_sb), 32'd1);
        check("prio_young_data_b", 32'(obs_db), 32'hAAAA);

        // Load-use: one bubble, then forward from stage 1
        nops(3);
        set_dec(1, 0, 1, 0, 0, 0, 0, 5, 1, 1); cycle();
        i_stage_data = {16'h0, 16'hBEEF, 16'h0};
        set_dec(1, 0, 1, 5, 1, 0, 0, 0, 0, 0); cycle();
        check("lu_stall", 32'(obs_st), 32'd1);
        check("lu_cnt_stall", 32'(obs_cnt), 32'd1);
        cycle();
        check("lu_stall_rel", 32'(obs_st), 32'd0);
        check("lu_sel_a", 32'(obs_sa), 32'd2);
        check("lu_data_a", 32'(obs_da), 32'hBEEF);
        check("lu_cnt_after", 32'(obs_cnt), 32'd1);

        // Flush overrides a load-use stall and drops the decode writer
        nops(3);
        set_dec(1, 0, 1, 0, 0, 0, 0, 1, 1, 1); cycle();
        set_dec(1, 1, 1, 1, 1, 0, 0, 1, 1, 0); cycle();
        check("flush_stall", 32'(obs_st), 32'd0);
        set_dec(1, 0, 1, 1, 1, 0, 0, 0, 0, 0); cycle();
        check("flush_sel_a", 32'(obs_sa), 32'd2);
        check("flush_cnt", 32'(obs_cnt), 32'd1);

        // Freeze during a load-use stall
        nops(3);
        set_dec(1, 0, 1, 0, 0, 0, 0, 6, 1, 1); cycle();
        i_stage_data = {16'h0, 16'hC0DE, 16'h0};
        set_dec(0, 0, 1, 0, 0, 6, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("frz_stall", 32'(obs_st), 32'd1);
            check("frz_cnt", 32'(obs_cnt), 32'd1);
        end
        i_advance = 1'b1; cycle();
        check("frz_adv_stall", 32'(obs_st), 32'd1);
        cycle();
        check("frz_rel_stall", 32'(obs_st), 32'd0);
        check("frz_sel_b", 32'(obs_sb), 32'd2);
        check("frz_data_b", 32'(obs_db), 32'hC0DE);

        // Reset in the middle of a stall
        nops(3);
        set_dec(1, 0, 1, 0, 0, 0, 0, 4, 1, 1); cycle();
        set_dec(1, 0, 1, 4, 1, 0, 0, 0, 0, 0);
        i_rst = 1'b1; cycle();
        check("rst_mid_stall", 32'(obs_st), 32'd1);
        i_rst = 1'b0; cycle();
        check("rst_clr_stall", 32'(obs_st), 32'd0);
        check("rst_clr_sel", 32'(obs_sa), 32'd0);
        check("rst_clr_cnt", 32'(obs_cnt), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            i_rst = ($urandom_range(99) == 0);
            cycle();
        end
        i_rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
